// File: rtl/mac_result_drain.sv
// ---------------------------------------------------------------------------
// mac_result_drain
//
// Purpose:
//   Sequences a row of NUM_MACS multiply-accumulate cells through one tile:
//   clears them, gates their keep input over k_len accepted operand beats,
//   snapshots the final accumulators, then streams the lanes out one per
//   valid/ready handshake. Each lane is requantized with a logical right
//   shift followed by an unsigned saturate to OUT_WIDTH bits.
//
// Ports:
//   clk        clock
//   reset      asynchronous reset, active low
//   start      begin a tile (only looked at while idle)
//   k_len      number of operand beats to accumulate, latched on start
//   shift      requant right shift, latched on start
//   in_valid   feeder presents an operand beat to all MACs
//   in_ready   operand beats are accepted (accumulate phase only)
//   mac_reset  synchronous clear for the MAC cells (active high)
//   mac_keep   MAC hold control (1 = hold accumulator)
//   acc_in     MAC accumulators, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   out_data   requantized lane result
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   out_last   out_data belongs to lane NUM_MACS-1
//   busy       a tile is in progress
// ---------------------------------------------------------------------------
module mac_result_drain #(
   parameter int NUM_MACS    = 4,
   parameter int ACC_WIDTH   = 32,
   parameter int OUT_WIDTH   = 8,
   parameter int SHIFT_WIDTH = 5,
   parameter int KLEN_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [KLEN_WIDTH-1:0]         k_len,
   input  logic [SHIFT_WIDTH-1:0]        shift,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          mac_reset,
   output logic                          mac_keep,
   input  logic [NUM_MACS*ACC_WIDTH-1:0] acc_in,
   output logic [OUT_WIDTH-1:0]          out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic                          busy
);

   localparam int IDX_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MACS - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SETTLE, DRAIN} state_t;

   state_t                        state_reg;
   logic [KLEN_WIDTH-1:0]         k_len_reg;
   logic [KLEN_WIDTH-1:0]         beat_cnt_reg;
   logic [SHIFT_WIDTH-1:0]        shift_reg;
   logic [IDX_W-1:0]              idx_reg;
   logic [IDX_W-1:0]              idx_next;
   logic [NUM_MACS*ACC_WIDTH-1:0] snap_reg;
   logic [ACC_WIDTH-1:0]          snap_lane [NUM_MACS];
   logic [OUT_WIDTH-1:0]          out_data_reg;
   logic                          out_valid_reg;
   logic                          out_last_reg;
   logic                          in_ready_reg;
   logic                          mac_reset_reg;
   logic                          busy_reg;

   // Logical right shift, then clamp to the largest OUT_WIDTH-bit value.
   // Any bit left above OUT_WIDTH after the shift means overflow.
   function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] acc,
                                                    input logic [SHIFT_WIDTH-1:0] sh);
      logic [ACC_WIDTH-1:0] shifted;
      shifted = acc >> sh;
      if (|(shifted >> OUT_WIDTH))
         requant = '1;
      else
         requant = shifted[OUT_WIDTH-1:0];
   endfunction

   for (genvar gi = 0; gi < NUM_MACS; gi++) begin : g_lane
      assign snap_lane[gi] = snap_reg[gi*ACC_WIDTH +: ACC_WIDTH];
   end

   assign idx_next = idx_reg + 1'b1;

   // The keep gate must follow in_valid in the same cycle so that a beat is
   // folded into the accumulators exactly when it is accepted.
   assign mac_keep  = (state_reg == ACCUM) ? ~in_valid : 1'b1;

   assign in_ready  = in_ready_reg;
   assign mac_reset = mac_reset_reg;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign busy      = busy_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         k_len_reg     <= '0;
         beat_cnt_reg  <= '0;
         shift_reg     <= '0;
         idx_reg       <= '0;
         snap_reg      <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         in_ready_reg  <= 1'b0;
         mac_reset_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  k_len_reg     <= k_len;
                  shift_reg     <= shift;
                  mac_reset_reg <= 1'b1;
                  busy_reg      <= 1'b1;
                  state_reg     <= CLEAR;
               end
            end
            CLEAR: begin
               mac_reset_reg <= 1'b0;
               beat_cnt_reg  <= '0;
               if (k_len_reg != '0) begin
                  in_ready_reg <= 1'b1;
                  state_reg    <= ACCUM;
               end else begin
                  state_reg    <= SETTLE;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  if (beat_cnt_reg == k_len_reg - 1'b1) begin
                     in_ready_reg <= 1'b0;
                     state_reg    <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               // The last beat landed in the MACs at the previous edge, so
               // acc_in is final now. Lane 0 is presented straight from it.
               snap_reg      <= acc_in;
               idx_reg       <= '0;
               out_data_reg  <= requant(acc_in[ACC_WIDTH-1:0], shift_reg);
               out_last_reg  <= (NUM_MACS == 1);
               out_valid_reg <= 1'b1;
               state_reg     <= DRAIN;
            end
            DRAIN: begin
               if (out_ready) begin
                  if (idx_reg == LAST_IDX) begin
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                     busy_reg      <= 1'b0;
                     state_reg     <= IDLE;
                  end else begin
                     idx_reg      <= idx_next;
                     out_data_reg <= requant(snap_lane[idx_next], shift_reg);
                     out_last_reg <= (idx_next == LAST_IDX);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_result_drain.sv
// ---------------------------------------------------------------------------
// tb_mac_result_drain
//
// Drives mac_result_drain against a row of behavioural MAC cells. Expected
// lane sums are accumulated from the operands of every accepted beat and
// turned into expected outputs with plain shift/clamp arithmetic.
// ---------------------------------------------------------------------------
module tb_mac_result_drain;

   localparam int NUM_MACS    = 4;
   localparam int ACC_WIDTH   = 32;
   localparam int OUT_WIDTH   = 8;
   localparam int SHIFT_WIDTH = 5;
   localparam int KLEN_WIDTH  = 16;

   logic                          clk;
   logic                          reset;
   logic                          start;
   logic [KLEN_WIDTH-1:0]         k_len;
   logic [SHIFT_WIDTH-1:0]        shift;
   logic                          in_valid;
   logic                          in_ready;
   logic                          mac_reset;
   logic                          mac_keep;
   logic [NUM_MACS*ACC_WIDTH-1:0] acc_in;
   logic [OUT_WIDTH-1:0]          out_data;
   logic                          out_valid;
   logic                          out_ready;
   logic                          out_last;
   logic                          busy;

   logic [7:0]           a_op    [NUM_MACS];
   logic [7:0]           b_op    [NUM_MACS];
   logic [ACC_WIDTH-1:0] mac_acc [NUM_MACS];

   int total = 0;
   int bad   = 0;

   mac_result_drain #(
      .NUM_MACS(NUM_MACS), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH), .KLEN_WIDTH(KLEN_WIDTH)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .shift(shift),
      .in_valid(in_valid), .in_ready(in_ready), .mac_reset(mac_reset),
      .mac_keep(mac_keep), .acc_in(acc_in), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // MAC cells: synchronous clear, otherwise accumulate A*B unless held.
   for (genvar gi = 0; gi < NUM_MACS; gi++) begin : g_mac
      always @(posedge clk) begin
         if (mac_reset)
            mac_acc[gi] <= '0;
         else if (!mac_keep)
            mac_acc[gi] <= mac_acc[gi] + 32'(a_op[gi]) * 32'(b_op[gi]);
      end
      assign acc_in[gi*ACC_WIDTH +: ACC_WIDTH] = mac_acc[gi];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] requant_ref(input logic [31:0] sum, input int sh);
      logic [31:0] v;
      v = sum >> sh;
      return (v > 32'd255) ? 32'd255 : v;
   endfunction

   // vmode: 0 in_valid always 1, 1 alternating 1,0,1,..., 2 random
   // rmode: 0 out_ready always 1, 1 three stall cycles at lane 1, 2 random
   // opa/opb < 0 selects random operands per lane and beat
   task automatic run_tile(input int k, input int sh, input int vmode, input int rmode,
                           input int opa, input int opb, input bit poke_start,
                           input bit abort_drain);
      logic [31:0] exp_sum [NUM_MACS];
      int beats, cyc, idx, stall;
      bit v, r;
      for (int i = 0; i < NUM_MACS; i++) exp_sum[i] = '0;

      @(negedge clk);
      start = 1'b1; k_len = KLEN_WIDTH'(k); shift = SHIFT_WIDTH'(sh);
      @(negedge clk);
      start = 1'b0;
      check("clear_mac_reset", 32'(mac_reset), 1);
      check("clear_busy", 32'(busy), 1);
      check("clear_keep", 32'(mac_keep), 1);
      check("clear_in_ready", 32'(in_ready), 0);

      beats = 0; cyc = 0;
      if (k > 0) begin
         while (beats < k && cyc < 200) begin
            @(negedge clk);
            cyc++;
            check("accum_in_ready", 32'(in_ready), 1);
            check("accum_mac_reset", 32'(mac_reset), 0);
            case (vmode)
               0:       v = 1'b1;
               1:       v = (cyc % 2) == 1;
               default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            for (int i = 0; i < NUM_MACS; i++) begin
               a_op[i] = (opa < 0) ? 8'($urandom) : 8'(opa);
               b_op[i] = (opb < 0) ? 8'($urandom) : 8'(opb);
            end
            if (poke_start && cyc == 2) begin
               start = 1'b1; k_len = KLEN_WIDTH'(k + 5); shift = SHIFT_WIDTH'(sh + 1);
            end else begin
               start = 1'b0;
            end
            #1;
            check("accum_keep", 32'(mac_keep), 32'(!v));
            if (v) begin
               beats++;
               for (int i = 0; i < NUM_MACS; i++)
                  exp_sum[i] = exp_sum[i] + 32'(a_op[i]) * 32'(b_op[i]);
            end
         end
         if (cyc >= 200) check("beat_timeout", 32'(beats), 32'(k));
      end
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
      check("settle_out_valid", 32'(out_valid), 0);
      check("settle_in_ready", 32'(in_ready), 0);
      check("settle_keep", 32'(mac_keep), 1);

      @(negedge clk);
      check("first_out_valid", 32'(out_valid), 1);

      idx = 0; cyc = 0; stall = 0;
      while (idx < NUM_MACS && cyc < 100) begin
         check("drain_valid", 32'(out_valid), 1);
         check("drain_data", 32'(out_data), requant_ref(exp_sum[idx], sh));
         check("drain_last", 32'(out_last), 32'(idx == NUM_MACS - 1));
         check("drain_keep", 32'(mac_keep), 1);
         if (abort_drain && idx == 1) begin
            reset = 1'b0;
            #1;
            check("abort_out_valid", 32'(out_valid), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_keep", 32'(mac_keep), 1);
            out_ready = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         case (rmode)
            0: r = 1'b1;
            1: begin
               r = !(idx == 1 && stall < 3);
               if (!r) stall++;
            end
            default: r = ($urandom_range(0, 3) != 0);
         endcase
         out_ready = r;
         in_valid  = 1'($urandom);
         if (r) idx++;
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (cyc >= 100) check("drain_timeout", 32'(idx), NUM_MACS);
      check("done_out_valid", 32'(out_valid), 0);
      check("done_busy", 32'(busy), 0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; k_len = '0; shift = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < NUM_MACS; i++) begin
         a_op[i] = '0; b_op[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_mac_reset", 32'(mac_reset), 0);
      check("rst_mac_keep", 32'(mac_keep), 1);
      check("rst_busy", 32'(busy), 0);
      reset = 1'b1;
      @(negedge clk);

      run_tile(3, 0, 0, 0, 2, 3, 1'b0, 1'b0);      // 18 on every lane
      run_tile(3, 0, 0, 0, 10, 10, 1'b0, 1'b0);    // 300 saturates to 255
      run_tile(3, 2, 0, 0, 10, 10, 1'b0, 1'b0);    // 300 >> 2 = 75
      run_tile(3, 0, 1, 1, -1, -1, 1'b0, 1'b0);    // gapped beats, stalled drain
      run_tile(0, 0, 0, 0, -1, -1, 1'b0, 1'b0);    // empty tile: four zeros
      run_tile(3, 0, 0, 0, -1, -1, 1'b0, 1'b1);    // reset during drain
      run_tile(1, 0, 0, 0, 1, 1, 1'b0, 1'b0);      // fresh tile after reset
      run_tile(4, 1, 0, 0, -1, -1, 1'b1, 1'b0);    // start poked during accum
      repeat (10)
         run_tile(int'($urandom_range(0, 12)), int'($urandom_range(0, 31)),
                  2, 2, -1, -1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
